lenet_frame_scheduler: RTL and testbench
========================================

Name: lenet_frame_scheduler

Overview:
- Ping-pong scheduler for the two 28x28 preprocessed-frame buffers between the camera preprocessor (writer) and the LeNet core (reader).
- Allocates a buffer per incoming frame and tracks each buffer's state.
- Issues one-clock lenet_go pulses with the buffer to read, and reclaims buffers on inference completion.
- Sits between the preprocessing pipeline and the LeNet engine; replaces ad-hoc ready/go pairing with explicit buffer ownership.

Parameters:
- DROP_OLDEST, 1, 1 = writer overwrites the oldest FULL buffer when none is FREE; 0 = new frame is skipped.
- CNT_W, 16, width of drop_count; saturating.
- WDT_CYCLES, 1000000, watchdog limit in clk cycles (used only with LENET_WDT_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-clock pulse: preprocessor begins a frame
- frame_done  in  1  one-clock pulse: current frame fully written
- wr_grant  out  1  one-clock pulse: wr_buf_sel is valid for this frame
- wr_buf_sel  out  1  buffer index being written; held until next grant
- frame_skip  out  1  one-clock pulse: frame refused, no buffer available
- lenet_ready  in  1  level: LeNet idle and able to start
- lenet_done  in  1  one-clock pulse: inference finished, read buffer released
- lenet_go  out  1  one-clock pulse: start inference on rd_buf_sel
- rd_buf_sel  out  1  buffer index for LeNet; held from lenet_go until next lenet_go
- drop_count  out  CNT_W  number of frames dropped or skipped, saturating
- lenet_timeout  out  1  one-clock pulse on watchdog expiry (tied 0 without LENET_WDT_EN)

Behaviour:
- Reset values:
  - Both buffer states FREE.
  - All outputs 0.
  - Age flag cleared (buffer 0 is "older").
- Per-buffer state machine, 2 bits each:
  - FREE: to WRITING on allocation.
  - WRITING: to FULL on frame_done; the age flag then marks the other FULL buffer, if any, as older.
  - FULL: to READING on lenet_go.
  - READING: to FREE on lenet_done.
- Reader decision (registered, 1-cycle latency):
  - Condition: lenet_ready=1, no buffer READING, at least one FULL.
  - Pick the oldest FULL buffer; the next cycle lenet_go=1, rd_buf_sel=idx, and that buffer is READING.
  - At most one READING buffer at any time.
- Writer allocation on frame_start (response in the next cycle):
  - A FREE buffer exists: take it (lowest index if both FREE); wr_grant=1, wr_buf_sel=idx.
  - A buffer is already WRITING: restart into the same buffer; re-grant the same index; it stays WRITING.
  - No FREE and DROP_OLDEST=1: reclaim the oldest FULL buffer, grant it, drop_count+1.
  - No FREE and DROP_OLDEST=0, or no FULL buffer to reclaim: frame_skip=1, drop_count+1, no state change.
- Same-cycle priority: the reader decision is evaluated first. A buffer selected for lenet_go in that cycle cannot be reclaimed by the writer. A READING buffer is never reclaimed.
- frame_done with no WRITING buffer: ignored.
- lenet_done with no READING buffer: ignored.
- Same-cycle frame_done and lenet_done: both applied.
- Same-cycle lenet_done and reader decision: the decision uses the pre-update state, so the next go comes one cycle later at the earliest.
- drop_count saturates at all-ones.
- rst asserted mid-operation: all state returns immediately to the reset values. Any in-flight inference result is disowned; the next lenet_done after reset is ignored.

Optional Feature:
- Macro LENET_WDT_EN.
- Defined:
  - A counter runs while a buffer is READING and clears on lenet_done.
  - When it reaches WDT_CYCLES: force that buffer FREE, pulse lenet_timeout for 1 cycle, clear the counter. A late lenet_done is then ignored.
- Undefined: no counter; lenet_timeout tied 0; a READING buffer waits indefinitely.

Test Plan:
- Reset, then frame_start @t0 -> wr_grant=1, wr_buf_sel=0 @t0+1. frame_done with lenet_ready=1 -> lenet_go 1-cycle pulse, rd_buf_sel=0; lenet_done -> buffer 0 FREE.
- lenet_ready=0, three frames written (A, B, then C), DROP_OLDEST=1:
  - A->buf0, B->buf1.
  - C reclaims buf0; drop_count=1.
  - After lenet_ready=1: first lenet_go selects buf1 (B), then buf0 (C).
- Same as above with DROP_OLDEST=0 -> frame C gets frame_skip=1, no wr_grant, drop_count=1; LeNet later processes A then B.
- Buf0 READING, buf1 FULL, frame_start in the same cycle as lenet_done -> writer skips or reclaims nothing READING. Buf1 gets lenet_go no earlier than 2 cycles after lenet_done.
- rst pulse while buf0 READING and buf1 WRITING -> all outputs 0, both FREE. A subsequent lenet_done produces no change; the next frame_start is granted buf0.
- LENET_WDT_EN with WDT_CYCLES=16, lenet_go then no lenet_done -> lenet_timeout pulse exactly 16 cycles after the READING entry; buffer FREE; a late lenet_done is ignored.

Source files
------------

// File: rtl/lenet_frame_scheduler_if.sv
// lenet_frame_scheduler_if: handshake bundle between the frame scheduler,
// the camera preprocessor (frame_* / wr_*) and the LeNet core (lenet_* / rd_*).
// "slave" is the scheduler's view. "master" is the view of the surrounding
// system that drives the requests and consumes the grants.
interface lenet_frame_scheduler_if #(
  parameter int CNT_W = 16
);
  // preprocessor side
  logic             frame_start;
  logic             frame_done;
  logic             wr_grant;
  logic             wr_buf_sel;
  logic             frame_skip;
  // LeNet side
  logic             lenet_ready;
  logic             lenet_done;
  logic             lenet_go;
  logic             rd_buf_sel;
  // status
  logic [CNT_W-1:0] drop_count;
  logic             lenet_timeout;

  modport master (
    output frame_start, frame_done, lenet_ready, lenet_done,
    input  wr_grant, wr_buf_sel, frame_skip, lenet_go, rd_buf_sel,
           drop_count, lenet_timeout
  );

  modport slave (
    input  frame_start, frame_done, lenet_ready, lenet_done,
    output wr_grant, wr_buf_sel, frame_skip, lenet_go, rd_buf_sel,
           drop_count, lenet_timeout
  );
endinterface

// File: rtl/lenet_frame_scheduler.sv
// lenet_frame_scheduler: ownership tracker for the two 28x28 preprocessed
// frame buffers. Each buffer cycles FREE -> WRITING -> FULL -> READING -> FREE.
// The writer is granted a buffer per frame. The reader is handed the oldest
// FULL buffer when LeNet is idle.
// Optional read watchdog: define LENET_WDT_EN to enable it (limit WDT_CYCLES).
module lenet_frame_scheduler #(
  parameter int DROP_OLDEST = 1,
  parameter int CNT_W       = 16,
  parameter int WDT_CYCLES  = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  lenet_frame_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_WRITING = 2'd1,
    BUF_FULL    = 2'd2,
    BUF_READING = 2'd3
  } buf_state_t;

  // per-buffer status flags decoded from each buffer's FSM
  logic [1:0] is_free;
  logic [1:0] is_writing;
  logic [1:0] is_full;
  logic [1:0] is_reading;
  logic       any_reading;
  logic       any_writing;

  // age flag: index of the older buffer when both are FULL
  logic old_reg;

  // reader decision
  logic       rd_fire;
  logic       rd_idx;
  logic [1:0] rd_onehot;

  // writer decision
  logic [1:0] reclaim_mask;
  logic       wr_fire;
  logic       wr_idx;
  logic       wr_drop;
  logic       wr_skip;
  logic [1:0] wr_onehot;

  // frame completion and read release
  logic       fd_fire;
  logic       fd_idx;
  logic [1:0] fd_onehot;
  logic       release_fire;
  logic       wdt_fire;

  // registered outputs
  logic             wr_grant_reg;
  logic             wr_buf_sel_reg;
  logic             frame_skip_reg;
  logic             lenet_go_reg;
  logic             rd_buf_sel_reg;
  logic [CNT_W-1:0] drop_count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      buf_state_t state_reg;

      assign is_free[gi]    = (state_reg == BUF_FREE);
      assign is_writing[gi] = (state_reg == BUF_WRITING);
      assign is_full[gi]    = (state_reg == BUF_FULL);
      assign is_reading[gi] = (state_reg == BUF_READING);

      // ownership FSM of one buffer; the decisions below never target the
      // same buffer with two different transitions in one cycle
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= BUF_FREE;
        end else if (wr_onehot[gi]) begin
          state_reg <= BUF_WRITING;
        end else if (rd_onehot[gi]) begin
          state_reg <= BUF_READING;
        end else if (fd_onehot[gi]) begin
          state_reg <= BUF_FULL;
        end else if (release_fire && is_reading[gi]) begin
          state_reg <= BUF_FREE;
        end
      end
    end
  endgenerate

  assign any_reading = |is_reading;
  assign any_writing = |is_writing;

  // reader: hand the oldest FULL buffer to an idle LeNet, one reader at a time
  always_comb begin
    rd_fire   = bus.lenet_ready && !any_reading && (|is_full);
    rd_idx    = (&is_full) ? old_reg : is_full[1];
    rd_onehot = rd_fire ? (2'b01 << rd_idx) : 2'b00;
  end

  // writer: restart an unfinished frame in place, else take a FREE buffer,
  // else (optionally) reclaim the oldest FULL one the reader is not taking
  always_comb begin
    reclaim_mask = is_full & ~rd_onehot;
    wr_fire      = 1'b0;
    wr_idx       = 1'b0;
    wr_drop      = 1'b0;
    wr_skip      = 1'b0;
    if (bus.frame_start) begin
      if (any_writing) begin
        wr_fire = 1'b1;
        wr_idx  = is_writing[1];
      end else if (|is_free) begin
        wr_fire = 1'b1;
        wr_idx  = !is_free[0];
      end else if ((DROP_OLDEST != 0) && (|reclaim_mask)) begin
        wr_fire = 1'b1;
        wr_idx  = (&reclaim_mask) ? old_reg : reclaim_mask[1];
        wr_drop = 1'b1;
      end else begin
        wr_skip = 1'b1;
        wr_drop = 1'b1;
      end
    end
    wr_onehot = wr_fire ? (2'b01 << wr_idx) : 2'b00;
  end

  // a frame_start in the same cycle restarts the frame, so frame_done loses
  assign fd_fire      = bus.frame_done && !bus.frame_start && any_writing;
  assign fd_idx       = is_writing[1];
  assign fd_onehot    = fd_fire ? (2'b01 << fd_idx) : 2'b00;
  assign release_fire = any_reading && (bus.lenet_done || wdt_fire);

  // age flag and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      old_reg        <= 1'b0;
      wr_grant_reg   <= 1'b0;
      wr_buf_sel_reg <= 1'b0;
      frame_skip_reg <= 1'b0;
      lenet_go_reg   <= 1'b0;
      rd_buf_sel_reg <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      if (fd_fire) begin
        old_reg <= ~fd_idx;
      end
      wr_grant_reg   <= wr_fire;
      frame_skip_reg <= wr_skip;
      lenet_go_reg   <= rd_fire;
      if (wr_fire) begin
        wr_buf_sel_reg <= wr_idx;
      end
      if (rd_fire) begin
        rd_buf_sel_reg <= rd_idx;
      end
      if (wr_drop && (drop_count_reg != {CNT_W{1'b1}})) begin
        drop_count_reg <= drop_count_reg + 1'b1;
      end
    end
  end

`ifdef LENET_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] wdt_cnt_reg;
  logic             timeout_reg;

  // a real lenet_done in the expiry cycle wins over the timeout
  assign wdt_fire = any_reading && !bus.lenet_done &&
                    (wdt_cnt_reg == WDT_W'(WDT_CYCLES - 1));

  // count cycles spent READING; force the buffer free at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_cnt_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= wdt_fire;
      if (!any_reading || bus.lenet_done || wdt_fire) begin
        wdt_cnt_reg <= '0;
      end else begin
        wdt_cnt_reg <= wdt_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.lenet_timeout = timeout_reg;
`else
  assign wdt_fire          = 1'b0;
  assign bus.lenet_timeout = 1'b0;
`endif

  assign bus.wr_grant   = wr_grant_reg;
  assign bus.wr_buf_sel = wr_buf_sel_reg;
  assign bus.frame_skip = frame_skip_reg;
  assign bus.lenet_go   = lenet_go_reg;
  assign bus.rd_buf_sel = rd_buf_sel_reg;
  assign bus.drop_count = drop_count_reg;

endmodule

// File: tb/tb_lenet_frame_scheduler.sv
// tb_lenet_frame_scheduler: two schedulers (DROP_OLDEST=1 as "a",
// DROP_OLDEST=0 as "b") share one stimulus stream. A buffer-ownership model
// using completion timestamps predicts every output each cycle. Directed
// scenarios add hand-computed literal expectations.
module tb_lenet_frame_scheduler;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;
  localparam int WDT = 16;
  localparam int FREE = 0, WRITING = 1, FULL = 2, READING = 3;
  localparam int O_GRANT = 0, O_SEL = 1, O_SKIP = 2, O_GO = 3, O_RSEL = 4, O_DROP = 5, O_TO = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fs  = 1'b0;
  logic fd  = 1'b0;
  logic ld  = 1'b0;
  logic rdy = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  string onames [7] = '{"wr_grant", "wr_buf_sel", "frame_skip", "lenet_go",
                        "rd_buf_sel", "drop_count", "lenet_timeout"};

  lenet_frame_scheduler_if #(.CNT_W(CW)) bus_a ();
  lenet_frame_scheduler_if #(.CNT_W(CW)) bus_b ();

  assign bus_a.frame_start = fs;
  assign bus_a.frame_done  = fd;
  assign bus_a.lenet_done  = ld;
  assign bus_a.lenet_ready = rdy;
  assign bus_b.frame_start = fs;
  assign bus_b.frame_done  = fd;
  assign bus_b.lenet_done  = ld;
  assign bus_b.lenet_ready = rdy;

  lenet_frame_scheduler #(.DROP_OLDEST(1), .CNT_W(CW), .WDT_CYCLES(WDT)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  lenet_frame_scheduler #(.DROP_OLDEST(0), .CNT_W(CW), .WDT_CYCLES(WDT)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  int     m_st    [2][2];
  longint m_stamp [2][2];
  int     m_drop [2], m_grant [2], m_sel [2], m_skip [2];
  int     m_go [2], m_rsel [2], m_to [2], m_wdt [2];
  longint cyc = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < 2; b++) begin
        m_st[i][b]    = FREE;
        m_stamp[i][b] = 0;
      end
      m_drop[i] = 0; m_grant[i] = 0; m_sel[i] = 0; m_skip[i] = 0;
      m_go[i] = 0; m_rsel[i] = 0; m_to[i] = 0; m_wdt[i] = 0;
    end
  endtask

  function automatic int oldest_full(int i, int excl);
    int best;
    best = -1;
    for (int b = 0; b < 2; b++) begin
      if (m_st[i][b] == FULL && b != excl) begin
        if (best < 0 || m_stamp[i][b] < m_stamp[i][best]) best = b;
      end
    end
    return best;
  endfunction

  // one clock of the ownership rules, all decisions on the pre-edge state
  task automatic model_step(input int i);
    int w, r, pick, fr, idx;
    w = -1; r = -1; pick = -1; fr = -1; idx = -1;
    m_grant[i] = 0; m_skip[i] = 0; m_go[i] = 0; m_to[i] = 0;
    for (int b = 0; b < 2; b++) begin
      if (m_st[i][b] == WRITING) w = b;
      if (m_st[i][b] == READING) r = b;
    end
    if (rdy && r < 0) pick = oldest_full(i, -1);
    if (fs) begin
      if (w >= 0) idx = w;
      else if (m_st[i][0] == FREE) idx = 0;
      else if (m_st[i][1] == FREE) idx = 1;
      else begin
        fr = (i == 0) ? oldest_full(i, pick) : -1;
        if (fr >= 0) idx = fr;
        else m_skip[i] = 1;
        if (m_drop[i] < SAT) m_drop[i]++;
      end
      if (idx >= 0) begin
        m_st[i][idx] = WRITING;
        m_grant[i]   = 1;
        m_sel[i]     = idx;
      end
    end else if (fd && w >= 0) begin
      m_st[i][w]    = FULL;
      m_stamp[i][w] = cyc;
    end
    if (r >= 0) begin
      if (ld) begin
        m_st[i][r] = FREE;
        m_wdt[i]   = 0;
      end
`ifdef LENET_WDT_EN
      else if (m_wdt[i] == WDT - 1) begin
        m_st[i][r] = FREE;
        m_to[i]    = 1;
        m_wdt[i]   = 0;
      end else begin
        m_wdt[i]++;
      end
`endif
    end
    if (pick >= 0) begin
      m_st[i][pick] = READING;
      m_go[i]       = 1;
      m_rsel[i]     = pick;
    end
  endtask

  function automatic int model_out(int i, int k);
    case (k)
      O_GRANT: return m_grant[i];
      O_SEL:   return m_sel[i];
      O_SKIP:  return m_skip[i];
      O_GO:    return m_go[i];
      O_RSEL:  return m_rsel[i];
      O_DROP:  return m_drop[i];
      default: return m_to[i];
    endcase
  endfunction

  function automatic int dut_out(int i, int k);
    if (i == 0) begin
      case (k)
        O_GRANT: return int'(bus_a.wr_grant);
        O_SEL:   return int'(bus_a.wr_buf_sel);
        O_SKIP:  return int'(bus_a.frame_skip);
        O_GO:    return int'(bus_a.lenet_go);
        O_RSEL:  return int'(bus_a.rd_buf_sel);
        O_DROP:  return int'(bus_a.drop_count);
        default: return int'(bus_a.lenet_timeout);
      endcase
    end else begin
      case (k)
        O_GRANT: return int'(bus_b.wr_grant);
        O_SEL:   return int'(bus_b.wr_buf_sel);
        O_SKIP:  return int'(bus_b.frame_skip);
        O_GO:    return int'(bus_b.lenet_go);
        O_RSEL:  return int'(bus_b.rd_buf_sel);
        O_DROP:  return int'(bus_b.drop_count);
        default: return int'(bus_b.lenet_timeout);
      endcase
    end
  endfunction

  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, want, $time);
  endtask

  task automatic lit(input string tag, input int i, input int k, input int want);
    check($sformatf("%s %s.%s", tag, (i == 0) ? "a" : "b", onames[k]), dut_out(i, k), want);
  endtask

  // model advances on each rising edge
  initial begin : model_proc
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else begin
        model_step(0);
        model_step(1);
      end
      cyc++;
    end
  end

  // compare every output of both instances on each falling edge
  initial begin : cmp_proc
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 7; k++) begin
          check($sformatf("cyc%0d %s.%s", cyc, (i == 0) ? "a" : "b", onames[k]),
                dut_out(i, k), model_out(i, k));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit s, input bit d, input bit l);
    fs = s; fd = d; ld = l;
    @(posedge clk);
    #1;
    fs = 1'b0; fd = 1'b0; ld = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; fs = 1'b0; fd = 1'b0; ld = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      lit("rst", i, O_GRANT, 0);
      lit("rst", i, O_SEL, 0);
      lit("rst", i, O_GO, 0);
      lit("rst", i, O_RSEL, 0);
      lit("rst", i, O_DROP, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : drive
    int r;
    // basic write, read, release
    do_reset();
    rdy = 1'b1;
    step(1, 0, 0);
    lit("s1", 0, O_GRANT, 1); lit("s1", 0, O_SEL, 0);
    step(0, 1, 0);
    lit("s1", 0, O_GO, 0);
    step(0, 0, 0);
    lit("s1", 0, O_GO, 1); lit("s1", 0, O_RSEL, 0);
    step(0, 0, 0);
    lit("s1", 0, O_GO, 0);
    step(0, 0, 1);
    step(1, 0, 0);
    lit("s1", 0, O_GRANT, 1); lit("s1", 0, O_SEL, 0);

    // three frames with LeNet busy: a reclaims, b skips
    do_reset();
    rdy = 1'b0;
    step(1, 0, 0);
    lit("s2A", 0, O_SEL, 0); lit("s2A", 1, O_SEL, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    lit("s2B", 0, O_SEL, 1); lit("s2B", 1, O_SEL, 1);
    step(0, 1, 0);
    step(1, 0, 0);
    lit("s2C", 0, O_GRANT, 1); lit("s2C", 0, O_SEL, 0); lit("s2C", 0, O_DROP, 1);
    lit("s2C", 1, O_GRANT, 0); lit("s2C", 1, O_SKIP, 1); lit("s2C", 1, O_DROP, 1);
    step(0, 1, 0);
    rdy = 1'b1;
    step(0, 0, 0);
    lit("s2go1", 0, O_GO, 1); lit("s2go1", 0, O_RSEL, 1);
    lit("s2go1", 1, O_GO, 1); lit("s2go1", 1, O_RSEL, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    lit("s2done", 0, O_GO, 0);
    step(0, 0, 0);
    lit("s2go2", 0, O_GO, 1); lit("s2go2", 0, O_RSEL, 0);
    lit("s2go2", 1, O_GO, 1); lit("s2go2", 1, O_RSEL, 1);
    step(0, 0, 1);

    // frame_start together with lenet_done while buf0 READING, buf1 FULL
    do_reset();
    rdy = 1'b0;
    step(1, 0, 0); step(0, 1, 0);
    step(1, 0, 0); step(0, 1, 0);
    rdy = 1'b1;
    step(0, 0, 0);
    lit("s4go", 0, O_RSEL, 0); lit("s4go", 1, O_GO, 1);
    step(1, 0, 1);
    lit("s4", 0, O_GRANT, 1); lit("s4", 0, O_SEL, 1); lit("s4", 0, O_DROP, 1);
    lit("s4", 1, O_SKIP, 1); lit("s4", 1, O_GO, 0);
    step(0, 0, 0);
    lit("s4+2", 1, O_GO, 1); lit("s4+2", 1, O_RSEL, 1); lit("s4+2", 0, O_GO, 0);
    step(0, 1, 0);
    step(0, 0, 0);

    // reset while buf0 READING and buf1 WRITING
    do_reset();
    rdy = 1'b1;
    step(1, 0, 0); step(0, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    lit("s5pre", 0, O_SEL, 1);
    do_reset();
    step(0, 0, 1);
    lit("s5", 0, O_GO, 0); lit("s5", 1, O_GRANT, 0);
    step(1, 0, 0);
    lit("s5", 0, O_GRANT, 1); lit("s5", 0, O_SEL, 0); lit("s5", 1, O_SEL, 0);

    // drop_count saturation
    do_reset();
    rdy = 1'b0;
    step(1, 0, 0); step(0, 1, 0);
    step(1, 0, 0); step(0, 1, 0);
    for (int n = 0; n < 20; n++) begin
      step(1, 0, 0);
      step(0, 1, 0);
    end
    lit("sat", 0, O_DROP, SAT); lit("sat", 1, O_DROP, SAT);

`ifdef LENET_WDT_EN
    // watchdog expiry with no lenet_done
    do_reset();
    rdy = 1'b0;
    step(1, 0, 0); step(0, 1, 0);
    rdy = 1'b1;
    step(0, 0, 0);
    rdy = 1'b0;
    lit("wdt", 0, O_GO, 1);
    for (int n = 0; n < 15; n++) step(0, 0, 0);
    lit("wdt15", 0, O_TO, 0);
    step(0, 0, 0);
    lit("wdt16", 0, O_TO, 1);
    step(0, 0, 1);
    lit("wdtlate", 0, O_TO, 0);
    step(1, 0, 0);
    lit("wdtlate", 0, O_SEL, 0);
`endif

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        r   = int'($urandom_range(0, 15));
        rdy = ($urandom_range(0, 3) != 0);
        step(r < 2, (r >= 2) && (r < 5), $urandom_range(0, 7) == 0);
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
